mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Zero-wait access is 2 cycles to ack; a stuck memory is aborted after TIMEOUT cycles and flagged in err_o.
module mem_arbiter #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [DW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_ack_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [DW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  input  logic [1:0]    d_memtype_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_ack_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [1:0]    mem_memtype_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_ready_i,
  output logic          stall_o,
  output logic          err_o
);

  typedef enum logic [1:0] {IDLE, ACC_IF, ACC_D, DONE} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t        state_q, state_d;
  logic          port_q, port_d;      // 1 = data port owns the access
  logic          last_q, last_d;      // 1 = data port was granted last
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    memtype_q, memtype_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          gnt_d;
  logic          acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      port_q     <= 1'b0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      memtype_q  <= 2'b00;
      cnt_q      <= 8'd0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      memtype_q  <= memtype_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    last_d     = last_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    memtype_d  = memtype_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    // On contention the port that lost last time wins.
    gnt_d      = d_req_i & (~if_req_i | ~last_q);
    case (state_q)
      IDLE: begin
        if (if_req_i || d_req_i) begin
          port_d    = gnt_d;
          last_d    = gnt_d;
          we_d      = gnt_d & d_we_i;
          addr_d    = gnt_d ? d_addr_i : if_addr_i;
          wdata_d   = gnt_d ? d_wdata_i : '0;
          memtype_d = gnt_d ? d_memtype_i : 2'b10;
          cnt_d     = 8'd0;
          state_d   = gnt_d ? ACC_D : ACC_IF;
        end
      end
      ACC_IF, ACC_D: begin
        if (mem_ready_i) begin
          if (!we_q) begin
            if (port_q) d_rdata_d = mem_rdata_i;
            else        if_rdata_d = mem_rdata_i;
          end
          state_d = DONE;
        end else if (cnt_q + 8'd1 == TO_LIMIT) begin
          // Abort: reads return zero, the error stays latched until reset.
          if (!we_q) begin
            if (port_q) d_rdata_d = '0;
            else        if_rdata_d = '0;
          end
          err_d   = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign acc           = (state_q == ACC_IF) || (state_q == ACC_D);
  assign mem_req_o     = acc;
  assign mem_we_o      = acc & we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign mem_memtype_o = memtype_q;
  assign if_ack_o      = (state_q == DONE) & ~port_q;
  assign d_ack_o       = (state_q == DONE) & port_q;
  assign if_rdata_o    = if_rdata_q;
  assign d_rdata_o     = d_rdata_q;
  assign err_o         = err_q;
  assign stall_o       = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, round-robin, wait states, timeout and async reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i, d_req_i, d_we_i, mem_ready_i;
  logic [31:0] if_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
  logic [1:0]  d_memtype_i;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  logic        if_ack_o, d_ack_o, mem_req_o, mem_we_o, stall_o, err_o;
  logic [1:0]  mem_memtype_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_memtype_i(d_memtype_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_memtype_o(mem_memtype_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .stall_o(stall_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Enter the next cycle just after its rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well before the falling edge.
  task automatic mid();
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    if_req_i = 0; d_req_i = 0; d_we_i = 0; mem_ready_i = 0;
    if_addr_i = 0; d_addr_i = 0; d_wdata_i = 0; mem_rdata_i = 0; d_memtype_i = 2'b00;
    cyc(); cyc(); mid();
    chk("rst_mem_req", {31'd0, mem_req_o}, 0);
    chk("rst_acks", {30'd0, if_ack_o, d_ack_o}, 0);
    chk("rst_err", {31'd0, err_o}, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    chk("rst_d_rdata", d_rdata_o, 0);
    rst_n = 1'b1;

    // Simultaneous fetch + load right after reset: data wins first.
    cyc();
    if_req_i = 1; if_addr_i = 32'h20;
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h100; d_memtype_i = 2'b10;
    mem_ready_i = 1; mem_rdata_i = 32'h11112222;
    mid();
    chk("sim_c0_req", {31'd0, mem_req_o}, 0);
    chk("sim_c0_stall", {31'd0, stall_o}, 1);
    cyc(); mid();
    chk("sim_c1_req", {31'd0, mem_req_o}, 1);
    chk("sim_c1_addr", mem_addr_o, 32'h100);
    cyc(); mid();
    chk("sim_c2_dack", {31'd0, d_ack_o}, 1);
    chk("sim_c2_ifack", {31'd0, if_ack_o}, 0);
    chk("sim_c2_drdata", d_rdata_o, 32'h11112222);
    chk("sim_c2_stall", {31'd0, stall_o}, 1);
    d_req_i = 0; mem_rdata_i = 32'h33334444;
    cyc(); mid();
    chk("sim_c3_req", {31'd0, mem_req_o}, 0);
    chk("sim_c3_stall", {31'd0, stall_o}, 1);
    cyc(); mid();
    chk("sim_c4_req", {31'd0, mem_req_o}, 1);
    chk("sim_c4_addr", mem_addr_o, 32'h20);
    chk("sim_c4_memtype", {30'd0, mem_memtype_o}, 2);
    cyc(); mid();
    chk("sim_c5_ifack", {31'd0, if_ack_o}, 1);
    chk("sim_c5_ifrdata", if_rdata_o, 32'h33334444);
    chk("sim_c5_drdata_hold", d_rdata_o, 32'h11112222);
    chk("sim_c5_stall", {31'd0, stall_o}, 0);
    if_req_i = 0;

    // Zero-wait fetch.
    cyc();
    if_req_i = 1; if_addr_i = 32'h10; mem_ready_i = 1; mem_rdata_i = 32'h00500093;
    mid();
    chk("zw_c0_req", {31'd0, mem_req_o}, 0);
    cyc(); mid();
    chk("zw_c1_req", {31'd0, mem_req_o}, 1);
    chk("zw_c1_addr", mem_addr_o, 32'h10);
    chk("zw_c1_we", {31'd0, mem_we_o}, 0);
    cyc(); mid();
    chk("zw_c2_req", {31'd0, mem_req_o}, 0);
    chk("zw_c2_ack", {31'd0, if_ack_o}, 1);
    chk("zw_c2_rdata", if_rdata_o, 32'h00500093);
    if_req_i = 0; mem_ready_i = 0;
    cyc(); mid();
    chk("zw_c3_ack", {31'd0, if_ack_o}, 0);
    chk("zw_c3_hold", if_rdata_o, 32'h00500093);

    // Store with three wait states.
    cyc();
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h200; d_wdata_i = 32'hCAFEF00D; d_memtype_i = 2'b10;
    mem_rdata_i = 32'h99999999;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      if (c == 4) mem_ready_i = 1;
      mid();
      chk("st_req", {31'd0, mem_req_o}, 1);
      chk("st_we", {31'd0, mem_we_o}, 1);
      chk("st_wdata", mem_wdata_o, 32'hCAFEF00D);
      chk("st_ack_early", {31'd0, d_ack_o}, 0);
    end
    cyc(); mid();
    chk("st_c5_ack", {31'd0, d_ack_o}, 1);
    chk("st_c5_req", {31'd0, mem_req_o}, 0);
    chk("st_c5_rdata", d_rdata_o, 32'h11112222);
    d_req_i = 0; d_we_i = 0; mem_ready_i = 0;

    // Timeout on a fetch that never gets ready.
    cyc();
    if_req_i = 1; if_addr_i = 32'h40; mem_rdata_i = 32'hDEADBEEF;
    for (int c = 1; c <= 15; c++) begin
      cyc(); mid();
      chk("to_req", {31'd0, mem_req_o}, 1);
      chk("to_ack_early", {31'd0, if_ack_o}, 0);
      chk("to_err_early", {31'd0, err_o}, 0);
    end
    cyc(); mid();
    chk("to_c16_req", {31'd0, mem_req_o}, 0);
    chk("to_c16_ack", {31'd0, if_ack_o}, 1);
    chk("to_c16_rdata", if_rdata_o, 0);
    chk("to_c16_err", {31'd0, err_o}, 1);
    if_req_i = 0;
    cyc(); mid();
    chk("to_c17_err", {31'd0, err_o}, 1);
    chk("to_c17_ack", {31'd0, if_ack_o}, 0);

    // Arbiter keeps serving after a timeout.
    cyc();
    d_req_i = 1; d_addr_i = 32'h44; mem_ready_i = 1; mem_rdata_i = 32'h55;
    cyc(); cyc(); mid();
    chk("post_to_dack", {31'd0, d_ack_o}, 1);
    chk("post_to_drdata", d_rdata_o, 32'h55);
    chk("post_to_err", {31'd0, err_o}, 1);
    d_req_i = 0; mem_ready_i = 0;

    // Reset in cycle 2 of a five-wait load.
    cyc();
    d_req_i = 1; d_addr_i = 32'h300; mem_rdata_i = 32'h77;
    cyc(); mid();
    chk("rm_c1_req", {31'd0, mem_req_o}, 1);
    cyc(); mid();
    chk("rm_c2_req", {31'd0, mem_req_o}, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_req_drop", {31'd0, mem_req_o}, 0);
    chk("rm_err_clr", {31'd0, err_o}, 0);
    chk("rm_acks", {30'd0, if_ack_o, d_ack_o}, 0);
    chk("rm_drdata", d_rdata_o, 0);
    chk("rm_ifrdata", if_rdata_o, 0);
    chk("rm_we", {31'd0, mem_we_o}, 0);
    chk("rm_stall", {31'd0, stall_o}, 1);
    cyc();
    d_req_i = 0; mem_ready_i = 1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc(); mid();
      chk("rm_no_dack", {31'd0, d_ack_o}, 0);
      chk("rm_no_req", {31'd0, mem_req_o}, 0);
    end

    // Normal arbitration after release.
    cyc();
    if_req_i = 1; if_addr_i = 32'h80; mem_rdata_i = 32'hA5A5A5A5;
    cyc(); mid();
    chk("rel_req", {31'd0, mem_req_o}, 1);
    cyc(); mid();
    chk("rel_ack", {31'd0, if_ack_o}, 1);
    chk("rel_rdata", if_rdata_o, 32'hA5A5A5A5);
    chk("rel_err", {31'd0, err_o}, 0);
    if_req_i = 0; mem_ready_i = 0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
